md5_bf_job_scheduler: RTL and testbench

- Splits the full MD5 brute-force keyspace across N_CORES parallel brute-force cores (3-symbol engines).
- Each job fixes one leading character (CHAR_LO..CHAR_HI) at byte CHAR_POS of the host base string; a core searches the remaining symbols.
- Dispatches jobs to free cores, retires completed jobs, captures the first hit, aborts all cores and reports to the host processor interface.

---
 rtl/md5_bf_job_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_md5_bf_job_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_bf_job_scheduler.sv
// Job scheduler for an array of MD5 brute-force cores: each job pins one leading
// character of the host template; the first reported hit aborts the whole array.
module md5_bf_job_scheduler #(
    parameter int N_CORES  = 4,
    parameter int STR_W    = 512,
    parameter int CHAR_LO  = 32,
    parameter int CHAR_HI  = 126,
    parameter int CHAR_POS = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       stop,
    input  logic [STR_W-1:0]           base_str,
    input  logic [31:0]                hash_a_in,
    input  logic [31:0]                hash_b_in,
    input  logic [31:0]                hash_c_in,
    input  logic [31:0]                hash_d_in,
    output logic [31:0]                hash_a_out,
    output logic [31:0]                hash_b_out,
    output logic [31:0]                hash_c_out,
    output logic [31:0]                hash_d_out,
    output logic                       busy,
    output logic                       found,
    output logic                       exhausted,
    output logic [STR_W-1:0]           result_str,
    output logic [7:0]                 jobs_issued,
    output logic [7:0]                 jobs_done,
    output logic [N_CORES-1:0]         core_start,
    output logic [STR_W-1:0]           job_str,
    output logic                       core_abort,
    input  logic [N_CORES-1:0]         core_done,
    input  logic [N_CORES-1:0]         core_found,
    input  logic [N_CORES*STR_W-1:0]   core_result
);

    localparam int         NJOBS     = CHAR_HI - CHAR_LO + 1;
    localparam int         IDX_W     = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam logic [8:0] CHAR_LO_W = 9'(CHAR_LO);
    localparam logic [8:0] CHAR_HI_W = 9'(CHAR_HI);
    localparam logic [8:0] NJOBS_W   = 9'(NJOBS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPATCH,
        S_FOUND,
        S_EXHAUSTED
    } state_t;

    state_t             state_q, state_d;
    logic [STR_W-1:0]   base_q, base_d;
    logic [31:0]        hash_a_q, hash_a_d;
    logic [31:0]        hash_b_q, hash_b_d;
    logic [31:0]        hash_c_q, hash_c_d;
    logic [31:0]        hash_d_q, hash_d_d;
    logic [N_CORES-1:0] assigned_q, assigned_d;
    logic [8:0]         next_char_q, next_char_d;
    logic               busy_q, busy_d;
    logic               found_q, found_d;
    logic               exhausted_q, exhausted_d;
    logic [STR_W-1:0]   result_q, result_d;
    logic [7:0]         issued_q, issued_d;
    logic [7:0]         done_cnt_q, done_cnt_d;
    logic [N_CORES-1:0] core_start_q, core_start_d;
    logic [STR_W-1:0]   job_str_q, job_str_d;
    logic               core_abort_q, core_abort_d;

    // Pulses from cores that hold no job are discarded here, before any use.
    logic [N_CORES-1:0] done_acc;
    logic [N_CORES-1:0] found_acc;
    logic [STR_W-1:0]   core_res_arr [N_CORES];

    genvar gi;
    generate
        for (gi = 0; gi < N_CORES; gi++) begin : g_core
            assign done_acc[gi]     = core_done[gi] & assigned_q[gi];
            assign found_acc[gi]    = core_found[gi] & assigned_q[gi];
            assign core_res_arr[gi] = core_result[gi*STR_W +: STR_W];
        end
    endgenerate

    logic [N_CORES-1:0] free_mask;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   hit_idx;
    logic [8:0]         done_pop;
    logic [8:0]         done_sum;
    logic [STR_W-1:0]   job_word;

    always_comb begin
        free_mask = ~(assigned_q & ~done_acc);
        free_idx  = '0;
        hit_idx   = '0;
        done_pop  = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (free_mask[i]) free_idx = IDX_W'(i);
            if (found_acc[i]) hit_idx = IDX_W'(i);
        end
        for (int i = 0; i < N_CORES; i++) begin
            done_pop = done_pop + 9'(done_acc[i]);
        end
        done_sum = {1'b0, done_cnt_q} + done_pop;
        job_word = base_q;
        job_word[CHAR_POS*8 +: 8] = next_char_q[7:0];
    end

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        hash_a_d     = hash_a_q;
        hash_b_d     = hash_b_q;
        hash_c_d     = hash_c_q;
        hash_d_d     = hash_d_q;
        assigned_d   = assigned_q & ~done_acc;
        next_char_d  = next_char_q;
        busy_d       = busy_q;
        found_d      = found_q;
        exhausted_d  = exhausted_q;
        result_d     = result_q;
        issued_d     = issued_q;
        done_cnt_d   = (done_sum > NJOBS_W) ? NJOBS_W[7:0] : done_sum[7:0];
        core_start_d = '0;
        job_str_d    = job_str_q;
        core_abort_d = 1'b0;

        case (state_q)
            S_DISPATCH: begin
                if (|found_acc) begin
                    result_d     = core_res_arr[hit_idx];
                    found_d      = 1'b1;
                    busy_d       = 1'b0;
                    core_abort_d = 1'b1;
                    assigned_d   = '0;
                    state_d      = S_FOUND;
                end else if (stop) begin
                    core_abort_d = 1'b1;
                    assigned_d   = '0;
                    busy_d       = 1'b0;
                    state_d      = S_IDLE;
                end else if ((next_char_q <= CHAR_HI_W) && (|free_mask)) begin
                    core_start_d[free_idx] = 1'b1;
                    assigned_d[free_idx]   = 1'b1;
                    job_str_d              = job_word;
                    next_char_d            = next_char_q + 9'd1;
                    issued_d               = (issued_q < NJOBS_W[7:0]) ? issued_q + 8'd1 : issued_q;
                end else if ((next_char_q > CHAR_HI_W) && (assigned_d == '0)) begin
                    // Only declared once the last outstanding job has retired.
                    exhausted_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_EXHAUSTED;
                end
            end
            default: begin
                if (start) begin
                    base_d      = base_str;
                    hash_a_d    = hash_a_in;
                    hash_b_d    = hash_b_in;
                    hash_c_d    = hash_c_in;
                    hash_d_d    = hash_d_in;
                    found_d     = 1'b0;
                    exhausted_d = 1'b0;
                    result_d    = '0;
                    issued_d    = '0;
                    done_cnt_d  = '0;
                    assigned_d  = '0;
                    next_char_d = CHAR_LO_W;
                    busy_d      = 1'b1;
                    state_d     = S_DISPATCH;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            hash_a_q     <= '0;
            hash_b_q     <= '0;
            hash_c_q     <= '0;
            hash_d_q     <= '0;
            assigned_q   <= '0;
            next_char_q  <= CHAR_LO_W;
            busy_q       <= 1'b0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            result_q     <= '0;
            issued_q     <= '0;
            done_cnt_q   <= '0;
            core_start_q <= '0;
            job_str_q    <= '0;
            core_abort_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            hash_a_q     <= hash_a_d;
            hash_b_q     <= hash_b_d;
            hash_c_q     <= hash_c_d;
            hash_d_q     <= hash_d_d;
            assigned_q   <= assigned_d;
            next_char_q  <= next_char_d;
            busy_q       <= busy_d;
            found_q      <= found_d;
            exhausted_q  <= exhausted_d;
            result_q     <= result_d;
            issued_q     <= issued_d;
            done_cnt_q   <= done_cnt_d;
            core_start_q <= core_start_d;
            job_str_q    <= job_str_d;
            core_abort_q <= core_abort_d;
        end
    end

    assign hash_a_out  = hash_a_q;
    assign hash_b_out  = hash_b_q;
    assign hash_c_out  = hash_c_q;
    assign hash_d_out  = hash_d_q;
    assign busy        = busy_q;
    assign found       = found_q;
    assign exhausted   = exhausted_q;
    assign result_str  = result_q;
    assign jobs_issued = issued_q;
    assign jobs_done   = done_cnt_q;
    assign core_start  = core_start_q;
    assign job_str     = job_str_q;
    assign core_abort  = core_abort_q;

endmodule

// File: tb/tb_md5_bf_job_scheduler.sv
// Directed bench for md5_bf_job_scheduler with a small emulated core array
// that returns job completion after a random 5-20 cycles.
module tb_md5_bf_job_scheduler;

    localparam int NC = 4;
    localparam int SW = 512;

    logic               clk = 1'b0;
    logic               reset, start, stop;
    logic [SW-1:0]      base_str;
    logic [31:0]        hash_a_in, hash_b_in, hash_c_in, hash_d_in;
    logic [31:0]        hash_a_out, hash_b_out, hash_c_out, hash_d_out;
    logic               busy, found, exhausted, core_abort;
    logic [SW-1:0]      result_str, job_str;
    logic [7:0]         jobs_issued, jobs_done;
    logic [NC-1:0]      core_start, core_done, core_found;
    logic [NC*SW-1:0]   core_result;

    md5_bf_job_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .base_str(base_str),
        .hash_a_in(hash_a_in), .hash_b_in(hash_b_in), .hash_c_in(hash_c_in), .hash_d_in(hash_d_in),
        .hash_a_out(hash_a_out), .hash_b_out(hash_b_out), .hash_c_out(hash_c_out), .hash_d_out(hash_d_out),
        .busy(busy), .found(found), .exhausted(exhausted), .result_str(result_str),
        .jobs_issued(jobs_issued), .jobs_done(jobs_done), .core_start(core_start), .job_str(job_str),
        .core_abort(core_abort), .core_done(core_done), .core_found(core_found), .core_result(core_result)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Emulated core array state
    int cnt   [NC];
    bit mbusy [NC];
    int seen  [256];
    int n_disp;
    int first_char;

    task automatic model_clear();
        for (int i = 0; i < NC; i++) begin
            mbusy[i] = 1'b0;
            cnt[i]   = 0;
        end
        for (int c = 0; c < 256; c++) seen[c] = 0;
        n_disp     = 0;
        first_char = -1;
    endtask

    task automatic model_step();
        int ch;
        core_done = '0;
        if ($countones(core_start) > 1) check_eq("start_onehot", SW'($countones(core_start)), SW'(1));
        if (core_abort) begin
            for (int i = 0; i < NC; i++) mbusy[i] = 1'b0;
        end
        for (int i = 0; i < NC; i++) begin
            if (core_start[i]) begin
                if (mbusy[i]) check_eq("start_to_busy_core", SW'(i), SW'(-1));
                ch = int'(job_str[31:24]);
                seen[ch]++;
                if (n_disp == 0) first_char = ch;
                n_disp++;
                mbusy[i] = 1'b1;
                cnt[i]   = int'($urandom_range(20, 5));
            end else if (mbusy[i]) begin
                cnt[i]--;
                if (cnt[i] == 0) begin
                    core_done[i] = 1'b1;
                    mbusy[i]     = 1'b0;
                end
            end
        end
    endtask

    task automatic run_model(input int stop_after, input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            tick();
            model_step();
            if (stop_after > 0 && n_disp >= stop_after) begin
                timed_out = 1'b0;
                return;
            end
            if (stop_after == 0 && exhausted) begin
                timed_out = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SW-1:0] exp_job;
        logic [SW-1:0] abc;
        bit            to;
        int            ab_cnt, st_cnt, once_cnt, outstanding;

        reset = 1'b1; start = 1'b0; stop = 1'b0; base_str = '0;
        hash_a_in = '0; hash_b_in = '0; hash_c_in = '0; hash_d_in = '0;
        core_done = '0; core_found = '0; core_result = '0;
        model_clear();
        repeat (3) tick();

        check_eq("rst_busy", SW'(busy), SW'(0));
        check_eq("rst_found", SW'(found), SW'(0));
        check_eq("rst_exhausted", SW'(exhausted), SW'(0));
        check_eq("rst_core_start", SW'(core_start), SW'(0));
        check_eq("rst_core_abort", SW'(core_abort), SW'(0));
        check_eq("rst_jobs_issued", SW'(jobs_issued), SW'(0));
        check_eq("rst_result", result_str, '0);
        reset = 1'b0;
        tick();

        // First search: four dispatches in order, then a hit on core 2
        abc = "abc";
        base_str  = abc;
        hash_a_in = 32'h0123_4567; hash_b_in = 32'h89ab_cdef;
        hash_c_in = 32'hfedc_ba98; hash_d_in = 32'h7654_3210;
        start = 1'b1;
        tick();
        start = 1'b0; base_str = '0;
        hash_a_in = '0; hash_b_in = '0; hash_c_in = '0; hash_d_in = '0;
        check_eq("start_busy", SW'(busy), SW'(1));
        check_eq("start_no_dispatch_yet", SW'(core_start), SW'(0));
        check_eq("hash_a_latched", SW'(hash_a_out), SW'(32'h0123_4567));
        check_eq("hash_d_latched", SW'(hash_d_out), SW'(32'h7654_3210));
        core_done = 4'b1000;
        for (int k = 0; k < NC; k++) begin
            tick();
            core_done = '0;
            exp_job = abc;
            exp_job[31:24] = 8'(32 + k);
            check_eq($sformatf("disp%0d_core_start", k), SW'(core_start), SW'(1 << k));
            check_eq($sformatf("disp%0d_job_str", k), job_str, exp_job);
            check_eq($sformatf("disp%0d_jobs_issued", k), SW'(jobs_issued), SW'(k + 1));
        end
        check_eq("spurious_done_ignored", SW'(jobs_done), SW'(0));
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("busy_start_ignored_issued", SW'(jobs_issued), SW'(4));
        check_eq("all_cores_busy_no_start", SW'(core_start), SW'(0));
        check_eq("busy_start_ignored_busy", SW'(busy), SW'(1));

        core_found = 4'b0100;
        core_result[2*SW +: SW] = "abz";
        tick();
        core_found = '0;
        check_eq("hit2_found", SW'(found), SW'(1));
        check_eq("hit2_result", result_str, SW'("abz"));
        check_eq("hit2_busy", SW'(busy), SW'(0));
        check_eq("hit2_abort", SW'(core_abort), SW'(1));
        check_eq("hit2_no_start", SW'(core_start), SW'(0));
        ab_cnt = 0; st_cnt = 0;
        repeat (5) begin
            tick();
            ab_cnt += int'(core_abort);
            st_cnt += $countones(core_start);
        end
        check_eq("hit2_single_abort", SW'(ab_cnt), SW'(0));
        check_eq("hit2_no_more_starts", SW'(st_cnt), SW'(0));
        check_eq("hit2_found_held", SW'(found), SW'(1));

        // Two simultaneous hits: lowest index wins
        base_str = "xyz";
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("restart_clears_found", SW'(found), SW'(0));
        check_eq("restart_clears_result", result_str, '0);
        check_eq("restart_clears_issued", SW'(jobs_issued), SW'(0));
        repeat (NC) tick();
        core_found = 4'b1010;
        core_result[1*SW +: SW] = "r1";
        core_result[3*SW +: SW] = "r3";
        tick();
        core_found = '0;
        check_eq("dual_hit_found", SW'(found), SW'(1));
        check_eq("dual_hit_result", result_str, SW'("r1"));

        // Done and found on the same core in the same cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (NC) tick();
        core_done  = 4'b0001;
        core_found = 4'b0001;
        core_result[0*SW +: SW] = "q0";
        tick();
        core_done = '0; core_found = '0;
        check_eq("donefound_found", SW'(found), SW'(1));
        check_eq("donefound_jobs_done", SW'(jobs_done), SW'(1));
        check_eq("donefound_result", result_str, SW'("q0"));
        core_result = '0;

        // Stop after ten dispatches
        base_str = abc;
        model_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_model(10, 500, to);
        check_eq("stop_run_timeout", SW'(to), SW'(0));
        stop = 1'b1;
        tick();
        stop = 1'b0; core_done = '0;
        check_eq("stop_abort", SW'(core_abort), SW'(1));
        check_eq("stop_busy", SW'(busy), SW'(0));
        check_eq("stop_found", SW'(found), SW'(0));
        check_eq("stop_jobs_issued", SW'(jobs_issued), SW'(10));
        tick();
        check_eq("stop_abort_one_cycle", SW'(core_abort), SW'(0));
        check_eq("stop_idle_no_start", SW'(core_start), SW'(0));

        // Restart and run the full keyspace with no match
        model_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("rerun_issued_zero", SW'(jobs_issued), SW'(0));
        check_eq("rerun_done_zero", SW'(jobs_done), SW'(0));
        run_model(0, 3000, to);
        core_done = '0;
        check_eq("exhaust_timeout", SW'(to), SW'(0));
        check_eq("rerun_first_char", SW'(first_char), SW'(32));
        check_eq("exhaust_dispatches", SW'(n_disp), SW'(95));
        once_cnt = 0;
        for (int c = 32; c <= 126; c++) if (seen[c] == 1) once_cnt++;
        check_eq("exhaust_chars_once", SW'(once_cnt), SW'(95));
        outstanding = 0;
        for (int i = 0; i < NC; i++) outstanding += int'(mbusy[i]);
        check_eq("exhaust_no_outstanding", SW'(outstanding), SW'(0));
        check_eq("exhaust_flag", SW'(exhausted), SW'(1));
        check_eq("exhaust_jobs_done", SW'(jobs_done), SW'(95));
        check_eq("exhaust_jobs_issued", SW'(jobs_issued), SW'(95));
        check_eq("exhaust_busy", SW'(busy), SW'(0));
        check_eq("exhaust_found", SW'(found), SW'(0));
        tick();
        check_eq("exhaust_hold", SW'(exhausted), SW'(1));
        check_eq("exhaust_no_start", SW'(core_start), SW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
